// File: rtl/washer_ctrl_gen2.sv
// Washing machine cycle controller.
// Runs FILL -> WASH -> DRAIN -> (RFILL -> RINSE -> RDRAIN) x RINSES -> SPIN -> DONE,
// scaling fill and agitate times by the latched load size. An open door freezes
// the active phase and its timer until the door closes again.
module washer_ctrl_gen2 #(
    parameter int LOAD_W    = 2,
    parameter int CNT_W     = 8,
    parameter int FILL_BASE = 4,
    parameter int WASH_BASE = 8,
    parameter int DRAIN_T   = 3,
    parameter int SPIN_T    = 5,
    parameter int RINSES    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic              Door,
    input  logic [LOAD_W-1:0] load,
    output logic              Agitator,
    output logic              Motor,
    output logic              Pump,
    output logic              Speed,
    output logic              Water,
    output logic              Busy,
    output logic              Paused,
    output logic              Done,
    output logic [3:0]        phase
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FILL   = 4'd1,
        ST_WASH   = 4'd2,
        ST_DRAIN  = 4'd3,
        ST_RFILL  = 4'd4,
        ST_RINSE  = 4'd5,
        ST_RDRAIN = 4'd6,
        ST_SPIN   = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  timer_r, timer_s;
    logic [LOAD_W-1:0] lq_r, lq_s;
    logic [3:0]        rinse_r, rinse_s;
    logic              paused_r, paused_s;
    // {phase[3:0], Water, Agitator, Motor, Pump, Speed, Busy, Paused, Done}
    logic [11:0]       out_r, out_s;

    // Phase length minus one: the value the timer is loaded with on entry.
    function automatic logic [CNT_W-1:0] dur_m1(input state_t st, input logic [LOAD_W-1:0] lq);
        logic [CNT_W-1:0] units;
        logic [CNT_W-1:0] d;
        units = CNT_W'(lq) + CNT_W'(1);
        case (st)
            ST_FILL, ST_RFILL:   d = CNT_W'(FILL_BASE) * units;
            ST_WASH, ST_RINSE:   d = CNT_W'(WASH_BASE) * units;
            ST_DRAIN, ST_RDRAIN: d = CNT_W'(DRAIN_T);
            ST_SPIN:             d = CNT_W'(SPIN_T);
            default:             d = CNT_W'(1);
        endcase
        return d - CNT_W'(1);
    endfunction

    // Phase that follows an active phase once its timer expires.
    function automatic state_t succ(input state_t st, input logic [3:0] rinse);
        state_t n;
        case (st)
            ST_FILL:   n = ST_WASH;
            ST_WASH:   n = ST_DRAIN;
            ST_DRAIN:  n = (RINSES == 0) ? ST_SPIN : ST_RFILL;
            ST_RFILL:  n = ST_RINSE;
            ST_RINSE:  n = ST_RDRAIN;
            ST_RDRAIN: n = (({1'b0, rinse} + 5'd1) < 5'(RINSES)) ? ST_RFILL : ST_SPIN;
            ST_SPIN:   n = ST_DONE;
            default:   n = ST_IDLE;
        endcase
        return n;
    endfunction

    // Actuator/status decode of a state and pause flag; paused phases drive nothing.
    function automatic logic [11:0] decode(input state_t st, input logic p);
        logic w, a, m, pu, sp;
        w  = 1'b0;
        a  = 1'b0;
        m  = 1'b0;
        pu = 1'b0;
        sp = 1'b0;
        if (!p) begin
            case (st)
                ST_FILL, ST_RFILL:   w = 1'b1;
                ST_WASH, ST_RINSE:   begin a = 1'b1; m = 1'b1; end
                ST_DRAIN, ST_RDRAIN: pu = 1'b1;
                ST_SPIN:             begin m = 1'b1; sp = 1'b1; pu = 1'b1; end
                default:             begin end
            endcase
        end else begin
            w = 1'b0;
        end
        return {4'(st), w, a, m, pu, sp, (st != ST_IDLE), p, (st == ST_DONE)};
    endfunction

    // Next-state logic: start latching, door freeze, timer countdown and phase advance.
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_r;
        lq_s     = lq_r;
        rinse_s  = rinse_r;
        paused_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Start && !Door) begin
                    state_s = ST_FILL;
                    lq_s    = load;
                    rinse_s = 4'd0;
                    timer_s = dur_m1(ST_FILL, load);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                timer_s = {CNT_W{1'b0}};
            end
            ST_FILL, ST_WASH, ST_DRAIN, ST_RFILL, ST_RINSE, ST_RDRAIN, ST_SPIN: begin
                // An open door wins over both decrement and advance.
                if (Door) begin
                    paused_s = 1'b1;
                end else if (timer_r != {CNT_W{1'b0}}) begin
                    timer_s = timer_r - CNT_W'(1);
                end else begin
                    state_s = succ(state_r, rinse_r);
                    timer_s = dur_m1(succ(state_r, rinse_r), lq_r);
                    if (state_r == ST_RDRAIN) begin
                        rinse_s = rinse_r + 4'd1;
                    end else begin
                        rinse_s = rinse_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output vector precomputed from next state so outputs come straight from flops.
    always_comb begin
        out_s = decode(state_s, paused_s);
    end

    // State, timer, latched load, rinse count, pause flag and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            timer_r  <= {CNT_W{1'b0}};
            lq_r     <= {LOAD_W{1'b0}};
            rinse_r  <= 4'd0;
            paused_r <= 1'b0;
            out_r    <= 12'd0;
        end else begin
            state_r  <= state_s;
            timer_r  <= timer_s;
            lq_r     <= lq_s;
            rinse_r  <= rinse_s;
            paused_r <= paused_s;
            out_r    <= out_s;
        end
    end

    assign {phase, Water, Agitator, Motor, Pump, Speed, Busy, Paused, Done} = out_r;

endmodule

// File: tb/tb_washer_ctrl_gen2.sv
// Randomized self-checking bench for washer_ctrl_gen2 with a segment-queue reference model.
`timescale 1ns/1ps
module tb_washer_ctrl_gen2;

    localparam int FB = 4;
    localparam int WB = 8;
    localparam int DT = 3;
    localparam int ST = 5;
    localparam int R  = 1;

    logic       clk = 1'b0;
    logic       reset, Start, Door;
    logic [1:0] load;
    logic       Agitator, Motor, Pump, Speed, Water, Busy, Paused, Done;
    logic [3:0] phase;

    logic       start_b;
    logic [1:0] load_b;
    logic       a0, m0, p0, s0, w0, busy0, pa0, done0;
    logic [3:0] ph0;
    logic       a2, m2, p2, s2, w2, busy2, pa2, done2;
    logic [3:0] ph2;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: remaining phases as a queue of (code, length) segments.
    int q_ph[$];
    int q_len[$];
    int m_phase = 0;
    int m_rem = 0;
    bit m_paused = 1'b0;
    logic [11:0] got;

    always #5 clk = ~clk;

    washer_ctrl_gen2 dut (
        .clk(clk), .reset(reset), .Start(Start), .Door(Door), .load(load),
        .Agitator(Agitator), .Motor(Motor), .Pump(Pump), .Speed(Speed), .Water(Water),
        .Busy(Busy), .Paused(Paused), .Done(Done), .phase(phase)
    );

    washer_ctrl_gen2 #(.RINSES(0)) dut_r0 (
        .clk(clk), .reset(reset), .Start(start_b), .Door(1'b0), .load(load_b),
        .Agitator(a0), .Motor(m0), .Pump(p0), .Speed(s0), .Water(w0),
        .Busy(busy0), .Paused(pa0), .Done(done0), .phase(ph0)
    );

    washer_ctrl_gen2 #(.RINSES(2)) dut_r2 (
        .clk(clk), .reset(reset), .Start(start_b), .Door(1'b0), .load(load_b),
        .Agitator(a2), .Motor(m2), .Pump(p2), .Speed(s2), .Water(w2),
        .Busy(busy2), .Paused(pa2), .Done(done2), .phase(ph2)
    );

    function automatic int seg_len(int ph, int lq);
        case (ph)
            1, 4:    return FB * (lq + 1);
            2, 5:    return WB * (lq + 1);
            3, 6:    return DT;
            7:       return ST;
            default: return 1;
        endcase
    endfunction

    function automatic int cycle_len(int lq, int r);
        return (FB + WB) * (lq + 1) * (r + 1) + DT * (r + 1) + ST + 1;
    endfunction

    function automatic logic [11:0] exp_vec();
        logic w, a, m, p, s;
        {w, a, m, p, s} = 5'b00000;
        if (!m_paused) begin
            case (m_phase)
                1, 4:    w = 1'b1;
                2, 5:    begin a = 1'b1; m = 1'b1; end
                3, 6:    p = 1'b1;
                7:       begin m = 1'b1; s = 1'b1; p = 1'b1; end
                default: begin end
            endcase
        end
        return {4'(m_phase), w, a, m, p, s, (m_phase != 0), m_paused, (m_phase == 8)};
    endfunction

    task automatic model_reset();
        q_ph.delete();
        q_len.delete();
        m_phase = 0;
        m_rem = 0;
        m_paused = 1'b0;
    endtask

    task automatic model_start(int lq);
        int seq[$];
        q_ph.delete();
        q_len.delete();
        seq = '{1, 2, 3};
        for (int i = 0; i < R; i++) begin
            seq.push_back(4); seq.push_back(5); seq.push_back(6);
        end
        seq.push_back(7);
        seq.push_back(8);
        foreach (seq[i]) begin
            q_ph.push_back(seq[i]);
            q_len.push_back(seg_len(seq[i], lq));
        end
        m_phase = q_ph.pop_front();
        m_rem = q_len.pop_front();
        m_paused = 1'b0;
    endtask

    task automatic model_step();
        if (m_phase == 0) begin
            m_paused = 1'b0;
            if (Start && !Door) model_start(int'(load));
        end else if (m_phase == 8) begin
            m_phase = 0;
            m_paused = 1'b0;
        end else if (Door) begin
            m_paused = 1'b1;
        end else begin
            m_paused = 1'b0;
            m_rem--;
            if (m_rem == 0) begin
                m_phase = q_ph.pop_front();
                m_rem = q_len.pop_front();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; Start = 1'b1; Door = 1'b0; load = 2'd3;
        model_reset();
        repeat (2) @(negedge clk);
        got = {phase, Water, Agitator, Motor, Pump, Speed, Busy, Paused, Done};
        vectors++;
        if (got !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_state: outputs %h, expected %h", got, exp_vec());
        end
        reset = 1'b0;
        tick();
        Start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            got = {phase, Water, Agitator, Motor, Pump, Speed, Busy, Paused, Done};
            vectors++;
            if (got !== exp_vec()) begin
                miscompares++;
                $display("FAIL start_after_reset cyc %0d: outputs %h, expected %h", c, got, exp_vec());
            end
            if (m_phase == 0) break;
            tick();
        end
    endtask

    task automatic test_nominal();
        int loads[$];
        int busy_n;
        loads = '{0, 2, 1, 3};
        for (int k = 0; k < 3; k++) loads.push_back(int'($urandom_range(0, 3)));
        foreach (loads[i]) begin
            Start = 1'b1; Door = 1'b0; load = 2'(loads[i]);
            tick();
            Start = 1'b0;
            busy_n = 0;
            for (int c = 0; c < 200; c++) begin
                got = {phase, Water, Agitator, Motor, Pump, Speed, Busy, Paused, Done};
                vectors++;
                if (got !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL nominal L%0d cyc %0d: outputs %h, expected %h", loads[i], c, got, exp_vec());
                end
                if (Busy) busy_n++;
                if (m_phase == 0) break;
                load = 2'($urandom_range(0, 3));
                tick();
            end
            vectors++;
            if (busy_n != cycle_len(loads[i], R)) begin
                miscompares++;
                $display("FAIL nominal_busy L%0d: busy %0d cycles, expected %0d", loads[i], busy_n, cycle_len(loads[i], R));
            end
        end
    endtask

    task automatic test_door_pause();
        int busy_n, ext, lq, lo, hi;
        for (int run = 0; run < 6; run++) begin
            lq = (run < 2) ? 0 : int'($urandom_range(0, 3));
            lo = (run == 0) ? 6 : 31;
            hi = (run == 0) ? 12 : 34;
            Start = 1'b1; Door = 1'b0; load = 2'(lq);
            tick();
            Start = 1'b0;
            busy_n = 0;
            ext = 0;
            for (int c = 0; c < 400; c++) begin
                got = {phase, Water, Agitator, Motor, Pump, Speed, Busy, Paused, Done};
                vectors++;
                if (got !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL door run%0d cyc %0d: outputs %h, expected %h", run, c, got, exp_vec());
                end
                if (Busy) busy_n++;
                if (m_phase == 0) break;
                Door = (run < 2) ? (c >= lo && c < hi) : ($urandom_range(0, 3) == 0);
                if (Door && m_phase >= 1 && m_phase <= 7) ext++;
                tick();
            end
            Door = 1'b0;
            vectors++;
            if (busy_n != cycle_len(lq, R) + ext) begin
                miscompares++;
                $display("FAIL door_busy run%0d: busy %0d cycles, expected %0d", run, busy_n, cycle_len(lq, R) + ext);
            end
        end
    endtask

    task automatic test_start_ignored();
        int busy_n;
        Start = 1'b1; Door = 1'b1; load = 2'd1;
        for (int c = 0; c < 4; c++) begin
            tick();
            got = {phase, Water, Agitator, Motor, Pump, Speed, Busy, Paused, Done};
            vectors++;
            if (got !== exp_vec()) begin
                miscompares++;
                $display("FAIL start_door_open cyc %0d: outputs %h, expected %h", c, got, exp_vec());
            end
        end
        Door = 1'b0; load = 2'd0;
        tick();
        busy_n = 0;
        for (int c = 0; c < 200; c++) begin
            got = {phase, Water, Agitator, Motor, Pump, Speed, Busy, Paused, Done};
            vectors++;
            if (got !== exp_vec()) begin
                miscompares++;
                $display("FAIL start_midcycle cyc %0d: outputs %h, expected %h", c, got, exp_vec());
            end
            if (Busy) busy_n++;
            if (m_phase == 0) break;
            Start = 1'($urandom_range(0, 1));
            tick();
        end
        Start = 1'b0;
        vectors++;
        if (busy_n != 36) begin
            miscompares++;
            $display("FAIL start_midcycle_busy: busy %0d cycles, expected 36", busy_n);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        Start = 1'b1; Door = 1'b0; load = 2'd0;
        tick();
        Start = 1'b0;
        for (int c = 0; c < 31; c++) begin
            if (Done) dones++;
            tick();
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        got = {phase, Water, Agitator, Motor, Pump, Speed, Busy, Paused, Done};
        vectors++;
        if (got !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_async_spin: outputs %h, expected %h", got, exp_vec());
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (Done) dones++;
            got = {phase, Water, Agitator, Motor, Pump, Speed, Busy, Paused, Done};
            vectors++;
            if (got !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_abort cyc %0d: outputs %h, expected %h", c, got, exp_vec());
            end
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: Done pulses %0d, expected 0", dones);
        end
    endtask

    task automatic test_rinses();
        int b0, b2, d0, d2;
        b0 = 0; b2 = 0; d0 = 0; d2 = 0;
        start_b = 1'b1; load_b = 2'd0;
        tick();
        start_b = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (busy0) b0++;
            if (busy2) b2++;
            if (done0) d0++;
            if (done2) d2++;
            load_b = 2'($urandom_range(0, 3));
            tick();
        end
        vectors += 4;
        if (b0 != cycle_len(0, 0)) begin
            miscompares++;
            $display("FAIL rinses0_busy: busy %0d cycles, expected %0d", b0, cycle_len(0, 0));
        end
        if (b2 != cycle_len(0, 2)) begin
            miscompares++;
            $display("FAIL rinses2_busy: busy %0d cycles, expected %0d", b2, cycle_len(0, 2));
        end
        if (d0 != 1) begin
            miscompares++;
            $display("FAIL rinses0_done: Done pulses %0d, expected 1", d0);
        end
        if (d2 != 1) begin
            miscompares++;
            $display("FAIL rinses2_done: Done pulses %0d, expected 1", d2);
        end
    endtask

    task automatic test_back_to_back();
        int runs;
        runs = 0;
        Start = 1'b1; Door = 1'b0; load = 2'($urandom_range(0, 3));
        tick();
        for (int c = 0; c < 400; c++) begin
            got = {phase, Water, Agitator, Motor, Pump, Speed, Busy, Paused, Done};
            vectors++;
            if (got !== exp_vec()) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: outputs %h, expected %h", c, got, exp_vec());
            end
            if (m_phase == 8) runs++;
            if (runs >= 2) Start = 1'b0;
            if (m_phase == 0 && runs >= 2) break;
            load = 2'($urandom_range(0, 3));
            tick();
        end
        Start = 1'b0;
        vectors++;
        if (runs != 2) begin
            miscompares++;
            $display("FAIL back_to_back_runs: completed %0d, expected 2", runs);
        end
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Door = 1'b0; load = 2'd0;
        start_b = 1'b0; load_b = 2'd0;
        test_reset();
        test_nominal();
        test_door_pause();
        test_start_ignored();
        test_reset_mid();
        test_rinses();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/washer_ctrl_gen2.md
WASHER_CTRL_GEN2 -- requirements
Module: washer_ctrl_gen2

Interface
REQ-001 Parameter LOAD_W, default 2, width of load-size input.
REQ-002 Parameter CNT_W, default 8, phase timer width.
REQ-003 Parameter FILL_BASE, default 4, fill cycles per load unit.
REQ-004 Parameter WASH_BASE, default 8, wash/rinse agitate cycles per load unit.
REQ-005 Parameter DRAIN_T, default 3, drain cycles (load-independent).
REQ-006 Parameter SPIN_T, default 5, spin cycles (load-independent).
REQ-007 Parameter RINSES, default 1, rinse passes (0..15).
REQ-008 Port clk  input  1  single clock, rising edge.
REQ-009 Port reset  input  1  asynchronous, active-high reset.
REQ-010 Port Start  input  1  level sampled each edge; starts cycle from IDLE.
REQ-011 Port Door  input  1  1 = door open.
REQ-012 Port load  input  LOAD_W  load size, latched at start.
REQ-013 Port Agitator, Motor, Pump, Speed, Water  output  1 each  actuator drives.
REQ-014 Port Busy  output  1  cycle in progress (any state but IDLE).
REQ-015 Port Paused  output  1  active phase frozen by open door.
REQ-016 Port Done  output  1  one-cycle completion pulse.
REQ-017 Port phase  output  4  state code: IDLE 0, FILL 1, WASH 2, DRAIN 3, RFILL 4, RINSE 5, RDRAIN 6, SPIN 7, DONE 8.

Function
REQ-018 Moore FSM; all outputs SHALL be decoded from registered state and pause flag only.
REQ-019 IDLE: Start=1 and Door=0 at an edge SHALL latch load into Lq, load FILL timer, enter FILL next cycle.
REQ-020 Start with Door=1, or Start in any non-IDLE state, SHALL be ignored.
REQ-021 Phase durations: FILL/RFILL = FILL_BASE*(Lq+1), WASH/RINSE = WASH_BASE*(Lq+1), DRAIN/RDRAIN = DRAIN_T, SPIN = SPIN_T cycles; computed at CNT_W bits, params SHALL satisfy max product < 2^CNT_W.
REQ-022 Timer SHALL load duration-1 on phase entry, decrement each unpaused cycle, advance phase on the unpaused cycle it reads 0.
REQ-023 Sequence: FILL -> WASH -> DRAIN -> {RFILL -> RINSE -> RDRAIN} x RINSES -> SPIN -> DONE -> IDLE; RINSES=0 SHALL go DRAIN -> SPIN.
REQ-024 Rinse counter SHALL clear on start, increment on RDRAIN exit; RDRAIN exits to RFILL while count < RINSES, else SPIN.
REQ-025 Outputs: FILL/RFILL Water=1; WASH/RINSE Agitator=1, Motor=1, Speed=0; DRAIN/RDRAIN Pump=1; SPIN Motor=1, Speed=1, Pump=1; all others 0.
REQ-026 DONE SHALL last exactly one cycle with Done=1, Busy=1, then IDLE.
REQ-027 Door=1 at an edge in FILL..SPIN SHALL set Paused next cycle; while Paused all actuators 0, timer and phase frozen.
REQ-028 Door=0 SHALL clear Paused next cycle; phase resumes with remaining count; total cycle extends by exactly the paused cycle count.
REQ-029 Door in IDLE or DONE SHALL have no effect; Paused=0 there.
REQ-030 Door open on the timer's terminal cycle SHALL hold the phase (pause wins over advance).
REQ-031 load changes after start SHALL not affect durations.

Reset
REQ-032 reset=1 SHALL immediately (asynchronously) force IDLE, timer 0, rinse count 0, Lq 0, Paused 0, all outputs 0.
REQ-033 Reset mid-cycle SHALL abort; restart requires new Start after reset release.
REQ-034 Start high during reset SHALL be ignored; sampled at first edge after release.

Verification (defaults unless stated)
REQ-035 load=0, Start 1 cycle -> Water 4, Agit/Motor 8, Pump 3, Water 4, Agit/Motor 8, Pump 3, Motor+Speed+Pump 5, Done pulse; Busy 36 cycles.
REQ-036 load=2 -> FILL 12, WASH 24, DRAIN 3, RFILL 12, RINSE 24, RDRAIN 3, SPIN 5; Busy 84 cycles.
REQ-037 load=0, Door=1 for 6 cycles mid-WASH -> Paused=1, actuators 0, phase=2 held; Busy 42 cycles; Door in SPIN likewise stops Motor.
REQ-038 Start with Door=1 -> phase stays 0; Start pulse mid-WASH -> no restart, timing unchanged.
REQ-039 reset pulse mid-SPIN -> phase=0, all outputs 0 before next edge; Done never pulses.
REQ-040 RINSES=0, load=0 -> FILL 4, WASH 8, DRAIN 3, SPIN 5, DONE; Busy 21 cycles; RINSES=2 -> two rinse passes, Busy 51.
